// File: rtl/led_pwm_pkg.sv
// led_pwm_pkg: shared constants, duty type and prescaler divisor helper for the LED PWM driver
package led_pwm_pkg;
    localparam int c_pwm_steps   = 255;
    localparam int c_pwm_cnt_max = 254;
    typedef logic [7:0] t_duty;
    function automatic int f_ce_divisor(input int fclk, input int pwm_frequency);
        int d;
        d = fclk / (pwm_frequency * c_pwm_steps);
        return (d < 1) ? 1 : d;
    endfunction
endpackage

// File: rtl/clock_enable_divider.sv
// clock_enable_divider: one-clock enable pulse every parm_divisor enabled clocks
module clock_enable_divider #(
    parameter int parm_divisor = 2
) (
    input  logic i_clk,
    input  logic i_srst,
    input  logic i_ce_mhz,
    output logic o_ce
);
    localparam int W = (parm_divisor > 1) ? $clog2(parm_divisor) : 1;
    logic [W-1:0] r_cnt;
    logic         w_ce;
    assign w_ce = i_ce_mhz && (r_cnt == W'(parm_divisor - 1));
    assign o_ce = w_ce;
    always_ff @(posedge i_clk) begin
        if (i_srst)
            r_cnt <= '0;
        else if (i_ce_mhz)
            r_cnt <= w_ce ? '0 : r_cnt + W'(1);
    end
endmodule

// File: rtl/led_pwm_channel.sv
// led_pwm_channel: per-channel duty shadow and registered compare output with optional inversion
module led_pwm_channel
    import led_pwm_pkg::*;
#(
    parameter int parm_active_low = 0
) (
    input  logic       i_clk,
    input  logic       i_srst,
    input  logic       i_load,
    input  t_duty      i_duty,
    input  logic [7:0] i_pwm_cnt,
    output logic       o_pin
);
    t_duty r_shadow;
    logic  r_pin;
    assign o_pin = r_pin;
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_shadow <= '0;
            r_pin    <= (parm_active_low != 0);
        end else begin
            if (i_load)
                r_shadow <= i_duty;
            r_pin <= (i_pwm_cnt < r_shadow) ^ (parm_active_low != 0);
        end
    end
endmodule

// File: rtl/led_pwm_frame_driver.sv
// led_pwm_frame_driver: 255-step PWM for RGB and basic LEDs with duties shadow-loaded once per frame
module led_pwm_frame_driver
    import led_pwm_pkg::*;
#(
    parameter int parm_color_led_count = 4,
    parameter int parm_basic_led_count = 4,
    parameter int parm_FCLK            = 40_000_000,
    parameter int parm_pwm_frequency   = 1_000,
    parameter int parm_active_low      = 0
) (
    input  logic                              i_clk,
    input  logic                              i_srst,
    input  logic [8*parm_color_led_count-1:0] i_color_led_red_value,
    input  logic [8*parm_color_led_count-1:0] i_color_led_green_value,
    input  logic [8*parm_color_led_count-1:0] i_color_led_blue_value,
    input  logic [8*parm_basic_led_count-1:0] i_basic_led_lumin_value,
    output logic [parm_color_led_count-1:0]   o_color_led_red,
    output logic [parm_color_led_count-1:0]   o_color_led_green,
    output logic [parm_color_led_count-1:0]   o_color_led_blue,
    output logic [parm_basic_led_count-1:0]   o_basic_led,
    output logic                              o_frame_strobe
);
    localparam int c_ce_divisor = f_ce_divisor(parm_FCLK, parm_pwm_frequency);
    localparam int c_ncl        = parm_color_led_count;
    localparam int c_nch        = 3 * c_ncl + parm_basic_led_count;
    logic               w_tick;
    logic               w_load;
    logic [7:0]         r_pwm_cnt;
    logic               r_load_pend;
    logic               r_frame_strobe;
    logic [8*c_nch-1:0] w_duty;
    logic [c_nch-1:0]   w_pin;
    clock_enable_divider #(
        .parm_divisor(c_ce_divisor)
    ) u_tick (
        .i_clk   (i_clk),
        .i_srst  (i_srst),
        .i_ce_mhz(1'b1),
        .o_ce    (w_tick)
    );
    // Pending flag forces a shadow reload on the first clock out of reset
    assign w_load = r_load_pend | (w_tick && (r_pwm_cnt == 8'(c_pwm_cnt_max)));
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_pwm_cnt      <= '0;
            r_load_pend    <= 1'b1;
            r_frame_strobe <= 1'b0;
        end else begin
            if (w_tick)
                r_pwm_cnt <= (r_pwm_cnt == 8'(c_pwm_cnt_max)) ? 8'd0 : r_pwm_cnt + 8'd1;
            r_load_pend    <= 1'b0;
            r_frame_strobe <= w_load;
        end
    end
    assign w_duty = {i_basic_led_lumin_value, i_color_led_blue_value,
                     i_color_led_green_value, i_color_led_red_value};
    for (genvar n = 0; n < c_nch; n++) begin : g_ch
        led_pwm_channel #(
            .parm_active_low(parm_active_low)
        ) u_ch (
            .i_clk    (i_clk),
            .i_srst   (i_srst),
            .i_load   (w_load),
            .i_duty   (w_duty[8*n +: 8]),
            .i_pwm_cnt(r_pwm_cnt),
            .o_pin    (w_pin[n])
        );
    end
    assign o_color_led_red   = w_pin[c_ncl-1:0];
    assign o_color_led_green = w_pin[2*c_ncl-1:c_ncl];
    assign o_color_led_blue  = w_pin[3*c_ncl-1:2*c_ncl];
    assign o_basic_led       = w_pin[c_nch-1:3*c_ncl];
    assign o_frame_strobe    = r_frame_strobe;
endmodule

// File: tb/tb_led_pwm_frame_driver.sv
// tb_led_pwm_frame_driver: randomized and directed checks of both polarities against a frame-arithmetic model
module tb_led_pwm_frame_driver;
    localparam int DIV   = 2;
    localparam int FRAME = 510;
    logic        clk = 1'b0;
    logic        srst = 1'b1;
    logic [31:0] red = '0, green = '0, blue = '0, basic = '0;
    logic [3:0]  a_red, a_green, a_blue, a_basic, b_red, b_green, b_blue, b_basic;
    logic        strb, strb2;
    logic [15:0] obs, obs2, exp_pin;
    logic        exp_strobe;
    int          checks = 0, errors = 0, m_k = 0, cyc = 0;
    logic [7:0]  m_sh [16];

    always #5 clk = ~clk;

    led_pwm_frame_driver #(.parm_FCLK(2550), .parm_pwm_frequency(5), .parm_active_low(0)) dut (
        .i_clk(clk), .i_srst(srst),
        .i_color_led_red_value(red), .i_color_led_green_value(green),
        .i_color_led_blue_value(blue), .i_basic_led_lumin_value(basic),
        .o_color_led_red(a_red), .o_color_led_green(a_green),
        .o_color_led_blue(a_blue), .o_basic_led(a_basic), .o_frame_strobe(strb));

    led_pwm_frame_driver #(.parm_FCLK(2550), .parm_pwm_frequency(5), .parm_active_low(1)) dut_al (
        .i_clk(clk), .i_srst(srst),
        .i_color_led_red_value(red), .i_color_led_green_value(green),
        .i_color_led_blue_value(blue), .i_basic_led_lumin_value(basic),
        .o_color_led_red(b_red), .o_color_led_green(b_green),
        .o_color_led_blue(b_blue), .o_basic_led(b_basic), .o_frame_strobe(strb2));

    assign obs  = {a_basic, a_blue, a_green, a_red};
    assign obs2 = {b_basic, b_blue, b_green, b_red};

    function automatic logic [7:0] duty_in(input int ch);
        logic [127:0] all;
        all = {basic, blue, green, red};
        return all[ch*8 +: 8];
    endfunction

    // Model: k counts clocks since reset release; step index and load edges follow from k directly
    task automatic step();
        logic [15:0] np;
        logic        ld;
        int          st;
        np = '0;
        ld = 1'b0;
        if (srst) begin
            m_k = 0;
            for (int c = 0; c < 16; c++) m_sh[c] = 8'd0;
        end else begin
            m_k++;
            st = ((m_k - 1) / DIV) % 255;
            ld = (m_k == 1) || (m_k % FRAME == 0);
            for (int c = 0; c < 16; c++) begin
                np[c] = st < int'(m_sh[c]);
                if (ld) m_sh[c] = duty_in(c);
            end
        end
        @(posedge clk);
        #1;
        exp_pin    = np;
        exp_strobe = ld;
        cyc++;
    endtask

    task automatic test_reset();
        srst = 1'b1;
        red = '1; green = '1; blue = '1; basic = '1;
        repeat (10) begin
            step();
            checks++;
            if (obs !== 16'h0 || strb !== 1'b0 || obs2 !== 16'hFFFF || strb2 !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: pins %h inv %h strobe %b, required 0000 FFFF 0", obs, obs2, strb);
            end
        end
        srst = 1'b0;
        step();
        checks++;
        if (strb !== 1'b1 || strb2 !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_strobe: strobe %b/%b, required 1", strb, strb2);
        end
        repeat (1020) begin
            step();
            checks++;
            if (obs !== 16'hFFFF || obs2 !== 16'h0 || strb !== exp_strobe || strb2 !== exp_strobe) begin
                errors++;
                $display("FAIL all_on cyc %0d: pins %h inv %h strobe %b, required FFFF 0000 %b", cyc, obs, obs2, strb, exp_strobe);
            end
        end
    endtask

    task automatic wait_strobe(input string tag);
        int w = 0;
        do begin
            step();
            w++;
            checks++;
            if (obs !== exp_pin || obs2 !== ~exp_pin || strb !== exp_strobe || strb2 !== exp_strobe) begin
                errors++;
                $display("FAIL %s_wait cyc %0d: pins %h inv %h strobe %b, required %h %b", tag, cyc, obs, obs2, strb, exp_pin, exp_strobe);
            end
        end while (strb !== 1'b1 && w < 600);
        checks++;
        if (strb !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: strobe %b, required 1 within 600 clocks", tag, strb);
        end
    endtask

    task automatic test_half_duty();
        int on = 0;
        logic [15:0] others = '0;
        red = 32'h0000_0080; green = '0; blue = '0; basic = '0;
        wait_strobe("half");
        repeat (FRAME) begin
            step();
            on += int'(obs[0]);
            others |= obs & 16'hFFFE;
            checks++;
            if (obs !== exp_pin || obs2 !== ~exp_pin || strb !== exp_strobe) begin
                errors++;
                $display("FAIL half_model cyc %0d: pins %h strobe %b, required %h %b", cyc, obs, strb, exp_pin, exp_strobe);
            end
        end
        checks++;
        if (on != 256 || others !== 16'h0) begin
            errors++;
            $display("FAIL half_count: red0 on %0d others %h, required 256 0000", on, others);
        end
    endtask

    task automatic test_extremes();
        int c0 = 0, c1 = 0;
        red = '0; green = '0; blue = '0; basic = 32'h0000_FF00;
        wait_strobe("ext");
        repeat (3 * FRAME) begin
            step();
            c0 += int'(obs[12]);
            c1 += int'(obs[13]);
            checks++;
            if (obs !== exp_pin || obs2 !== ~exp_pin || strb !== exp_strobe) begin
                errors++;
                $display("FAIL ext_model cyc %0d: pins %h strobe %b, required %h %b", cyc, obs, strb, exp_pin, exp_strobe);
            end
        end
        checks++;
        if (c0 != 0 || c1 != 3 * FRAME) begin
            errors++;
            $display("FAIL ext_count: duty00 on %0d dutyFF on %0d, required 0 1530", c0, c1);
        end
    endtask

    task automatic test_midframe_change();
        int on = 0;
        red = '0; blue = '0; basic = '0; green = 32'h0010_0000;
        wait_strobe("mid");
        for (int i = 0; i < FRAME; i++) begin
            if (i == 200) green = 32'h00F0_0000;
            step();
            on += int'(obs[6]);
            checks++;
            if (obs !== exp_pin || obs2 !== ~exp_pin || strb !== exp_strobe) begin
                errors++;
                $display("FAIL mid_model cyc %0d: pins %h strobe %b, required %h %b", cyc, obs, strb, exp_pin, exp_strobe);
            end
        end
        checks++;
        if (on != 32 || strb !== 1'b1) begin
            errors++;
            $display("FAIL mid_old_frame: green2 on %0d strobe %b, required 32 1", on, strb);
        end
        on = 0;
        repeat (FRAME) begin
            step();
            on += int'(obs[6]);
        end
        checks++;
        if (on != 480) begin
            errors++;
            $display("FAIL mid_new_frame: green2 on %0d, required 480", on);
        end
    endtask

    task automatic test_active_low();
        int lo = 0;
        red = '0; green = '0; blue = '0; basic = 32'h0040_0000;
        wait_strobe("al");
        repeat (FRAME) begin
            step();
            lo += int'(!obs2[14]);
            checks++;
            if (obs2 !== ~exp_pin || strb2 !== exp_strobe) begin
                errors++;
                $display("FAIL al_model cyc %0d: inv pins %h strobe %b, required %h %b", cyc, obs2, strb2, ~exp_pin, exp_strobe);
            end
        end
        checks++;
        if (lo != 128) begin
            errors++;
            $display("FAIL al_count: low clocks %0d high %0d, required 128 382", lo, FRAME - lo);
        end
    endtask

    task automatic test_reset_midframe();
        int on = 0, s1 = -1, s2 = -1;
        red = 32'h2020_2020; green = red; blue = red; basic = red;
        wait_strobe("rmid");
        repeat (300) step();
        srst = 1'b1;
        step();
        checks++;
        if (obs !== 16'h0 || obs2 !== 16'hFFFF || strb !== 1'b0) begin
            errors++;
            $display("FAIL rmid_reset: pins %h inv %h strobe %b, required 0000 FFFF 0", obs, obs2, strb);
        end
        srst = 1'b0;
        step();
        checks++;
        if (strb !== 1'b1) begin
            errors++;
            $display("FAIL rmid_reload: strobe %b, required 1", strb);
        end
        for (int k = 2; k < 1100; k++) begin
            step();
            if (k <= 511) on += int'(obs[0]);
            if (strb === 1'b1) begin
                if (s1 < 0) s1 = k;
                else if (s2 < 0) s2 = k;
            end
            checks++;
            if (obs !== exp_pin || obs2 !== ~exp_pin || strb !== exp_strobe) begin
                errors++;
                $display("FAIL rmid_model cyc %0d: pins %h strobe %b, required %h %b", cyc, obs, strb, exp_pin, exp_strobe);
            end
        end
        checks++;
        if (on != 64 || s2 - s1 != FRAME) begin
            errors++;
            $display("FAIL rmid_frame: on %0d strobe gap %0d, required 64 510", on, s2 - s1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1600; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                case ($urandom_range(0, 3))
                    0: red = $urandom;
                    1: green = $urandom;
                    2: blue = $urandom;
                    default: basic = $urandom;
                endcase
            end
            step();
            checks++;
            if (obs !== exp_pin || obs2 !== ~exp_pin || strb !== exp_strobe || strb2 !== exp_strobe) begin
                errors++;
                $display("FAIL rand_model cyc %0d: pins %h inv %h strobe %b, required %h %b", cyc, obs, obs2, strb, exp_pin, exp_strobe);
            end
        end
    endtask

    initial begin
        test_reset();
        test_half_duty();
        test_extremes();
        test_midframe_change();
        test_active_low();
        test_reset_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/led_pwm_frame_driver.md
Name: led_pwm_frame_driver

Overview:
- Consumes the packed 8-bit palette buses produced by the LED palette pulser and drives the physical LED pins.
- Four RGB color LEDs (3 channels each) plus four basic LEDs are driven with 255-step PWM.
- Duty values are shadow-latched once per PWM frame, so palette changes never glitch mid-period.
- Sits between the palette pulser and the board top-level LED pins.

Parameters:
- parm_color_led_count, 4, number of RGB LEDs
- parm_basic_led_count, 4, number of single-color LEDs
- parm_FCLK, 40_000_000, i_clk frequency in Hz
- parm_pwm_frequency, 1_000, PWM frame rate in Hz
- parm_active_low, 0, 1 = invert all LED outputs (pin on = 0)

Ports:
- i_clk  in  1  system clock
- i_srst  in  1  synchronous active-high reset
- i_color_led_red_value  in  8*parm_color_led_count  packed red duty, LED n at bits [8n+7:8n]
- i_color_led_green_value  in  8*parm_color_led_count  packed green duty
- i_color_led_blue_value  in  8*parm_color_led_count  packed blue duty
- i_basic_led_lumin_value  in  8*parm_basic_led_count  packed basic-LED duty
- o_color_led_red  out  parm_color_led_count  red pin drive
- o_color_led_green  out  parm_color_led_count  green pin drive
- o_color_led_blue  out  parm_color_led_count  blue pin drive
- o_basic_led  out  parm_basic_led_count  basic LED pin drive
- o_frame_strobe  out  1  one-clock pulse when the shadow load occurs

Behaviour:
- One clock (i_clk); reset i_srst is synchronous and active-high. All state is reset on the same edge.
- Step tick:
  - c_ce_divisor = parm_FCLK / (parm_pwm_frequency * 255), integer truncation, minimum 1.
  - A prescaler counts 0..c_ce_divisor-1; s_tick asserts for one clock when count == c_ce_divisor-1, then the count wraps to 0.
- Frame counter s_pwm_cnt:
  - 8 bits, range 0..254; increments on s_tick; wraps 254 -> 0.
  - Frame length = 255 * c_ce_divisor clocks.
- Shadow load (s_load) asserts on either condition:
  - s_tick with s_pwm_cnt == 254 (frame end), or
  - the first clock after reset deasserts (a load-pending flag is set during reset).
- Shadow load action:
  - On s_load, all 8-bit input fields are captured into per-channel shadow registers.
  - Inputs are ignored at every other time.
- o_frame_strobe: registered copy of s_load, so it is high the clock after the shadow capture.
- Compare: each channel's output register is updated every clock to on = (s_pwm_cnt < shadow).
  - duty 0: always off.
  - duty 255: always on (255 > 254 max count).
  - duty d: on for d steps per frame.
- Polarity: the pin value is on XOR parm_active_low.
- Latency: an input change is visible at the pins 2 clocks after the next s_load (1 clock to capture the shadow, 1 clock for the output register).
- Reset values:
  - Prescaler, s_pwm_cnt and all shadows = 0.
  - All LED outputs = off (0, or 1 if parm_active_low).
  - o_frame_strobe = 0.
- Reset mid-frame: reset takes effect immediately; the frame restarts from count 0 and the first post-reset clock reloads the shadows.
- Input change on the same clock as s_load: the new value is captured (the sample is taken at that edge).
- Simultaneous s_tick and reset: reset wins.

Decomposition:
- Package led_pwm_pkg:
  - c_pwm_steps = 255, c_pwm_cnt_max = 254.
  - Duty typedef t_duty (logic [7:0]).
  - Helper function for the divisor calculation with the minimum-1 clamp.
- Reuse the existing clock_enable_divider for s_tick (i_ce_mhz tied to 1).
- One natural sub-module, led_pwm_channel:
  - Holds the 8-bit shadow and the registered compare output.
  - Inputs: i_clk, i_srst, i_load, i_duty, i_pwm_cnt.
  - Generate-instantiate 3*color + basic copies.

Test Plan (parm_FCLK=2550, parm_pwm_frequency=5 -> divisor 2, frame = 510 clocks):
- Reset held 10 clocks, all inputs 0xFF:
  - During reset: all outputs 0, o_frame_strobe 0.
  - After release: strobe on the 2nd clock, then all outputs 1 continuously.
- Red LED0 = 0x80, rest 0x00: over one full frame, o_color_led_red[0] high exactly 256 clocks (128 steps * 2), others never high.
- Duty 0x00 and 0xFF on two basic LEDs: over 3 frames, 0 high-clocks and 1530 high-clocks respectively, no single-clock glitch at the wrap.
- Change green LED2 from 0x10 to 0xF0 mid-frame (count 100):
  - Current frame still shows 16 steps high.
  - The new value applies starting 2 clocks after the next o_frame_strobe.
- parm_active_low=1, duty 0x40: pin low for 128 clocks per frame, high for 382; reset drives all pins 1.
- Assert reset at count 150, inputs 0x20: counter restarts; the first post-reset frame has exactly 64 on-clocks and strobes 510 clocks apart.
